// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder block: FSM state encodings and
// a helper that sizes the bit counter for a given operand width.
// Latency: n/a (package). Backpressure: n/a (package).
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH, so it needs
  // clog2(WIDTH+1) bits; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
// Latency: combinational. Backpressure: none.
// Ports: a, b, ci (inputs) -> s (sum bit), co (carry out).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_rca_responder.sv
// Bit-serial ripple-carry adder: operands in over valid/ready, added LSB-first
// one bit per clock through one full-adder cell, {cout,sum} out over valid/ready.
// Latency: result valid WIDTH clocks after the input handshake edge; one op per WIDTH+2 clocks.
// Backpressure: result held in DONE until out_ready; in_ready low while RUN/DONE.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a/b/cin,
//        out_valid/out_ready/sum/cout, and ovf when SERIAL_RCA_OVF_EN is defined.
// Optional feature macro: SERIAL_RCA_OVF_EN (adds registered signed-overflow flag ovf).
module serial_rca_responder
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             accept;

  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the first
  // (LSB) result bit has arrived at position 0.
  always_comb begin
    sum_nxt            = sum_sh >> 1;
    sum_nxt[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_RCA_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == ST_RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_nxt;
        carry  <= fa_co;
        cnt    <= cnt + CW'(1);
        // Output registers only change when a full result is ready, so
        // sum/cout stay at the previous result throughout RUN.
        if (last_bit) begin
          sum  <= sum_nxt;
          cout <= fa_co;
`ifdef SERIAL_RCA_OVF_EN
          // On the MSB cycle 'carry' is the carry into the MSB.
          ovf  <= carry ^ fa_co;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rca_responder.sv
// Directed + random bench for serial_rca_responder at WIDTH=4, 1 and 8.
// Expected {cout,sum} (and ovf) are queued at input handshake and popped at output handshake.
module tb_serial_rca_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst;

  // WIDTH=4 instance
  logic       in_valid, cin, out_ready, in_ready, out_valid, cout;
  logic [3:0] a, b, sum;
  logic [4:0] q4[$];

  // WIDTH=1 instance
  logic       in_valid1, cin1, out_ready1, in_ready1, out_valid1, cout1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] q1[$];

  // WIDTH=8 instance
  logic       in_valid8, cin8, out_ready8, in_ready8, out_valid8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [8:0] q8[$];

`ifdef SERIAL_RCA_OVF_EN
  logic ovf, ovf1, ovf8;
  logic q4o[$];
  logic q1o[$];
  logic q8o[$];
`endif

  serial_rca_responder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef SERIAL_RCA_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_rca_responder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef SERIAL_RCA_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_rca_responder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
`ifdef SERIAL_RCA_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed overflow reference: carry into the MSB xor carry out of the MSB.
  function automatic logic ovf_model(input int w, input logic [7:0] x, input logic [7:0] y,
                                     input logic c);
    logic [8:0] lo_mask;
    logic [8:0] t;
    logic [8:0] full;
    lo_mask = (9'd1 << (w - 1)) - 9'd1;
    t       = ({1'b0, x} & lo_mask) + ({1'b0, y} & lo_mask) + {8'd0, c};
    full    = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return t[w-1] ^ full[w];
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(n < 40), 32'd1);
    in_valid = 1'b1;
    a = x; b = y; cin = c;
    q4.push_back({1'b0, x} + {1'b0, y} + {4'd0, c});
`ifdef SERIAL_RCA_OVF_EN
    q4o.push_back(ovf_model(4, {4'd0, x}, {4'd0, y}, c));
`endif
    @(negedge clk);
    in_valid = 1'b0;
    // Garbage on the operand pins must not affect the captured operation.
    a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd4);
  endtask

  task automatic recv4(input int stall);
    logic [4:0] e;
    chk("sb_size", 32'(q4.size()), 32'd1);
    if (q4.size() == 0) return;
    repeat (stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", 32'({cout, sum}), 32'(q4[0]));
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    e = q4.pop_front();
    chk("result", 32'({cout, sum}), 32'(e));
`ifdef SERIAL_RCA_OVF_EN
    chk("ovf", 32'(ovf), 32'(q4o.pop_front()));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'({cout, sum}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic ops
    send4(4'b0000, 4'b1111, 1'b0); recv4(0);
    send4(4'b1111, 4'b1111, 1'b0); recv4(1);
    send4(4'b1111, 4'b1111, 1'b1); recv4(0);

    // Long backpressure
    send4(4'b1010, 4'b1111, 1'b0); recv4(10);

    // Reset in the middle of RUN (two bits processed)
    in_valid = 1'b1; a = 4'b1011; b = 4'b0110; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'({cout, sum}), 32'd0);
    send4(4'b0011, 4'b0001, 1'b0); recv4(0);

    // Back-to-back directed ops plus a short random run
    send4(4'b0101, 4'b0110, 1'b1); recv4(0);
    send4(4'b1001, 4'b0111, 1'b0); recv4(0);
    for (int i = 0; i < 12; i++) begin
      send4(4'($urandom), 4'($urandom), 1'($urandom));
      recv4($urandom_range(0, 3));
    end

`ifdef SERIAL_RCA_OVF_EN
    send4(4'b0111, 4'b0001, 1'b0); recv4(0);
    send4(4'b1000, 4'b1000, 1'b0); recv4(0);
    send4(4'b0011, 4'b0100, 1'b0); recv4(0);
`endif

    // Random sweep, WIDTH=1
    for (int i = 0; i < 16; i++) begin
      int n;
      n = 0;
      while (!in_ready1 && n < 40) begin @(negedge clk); n++; end
      chk("w1_ready_wait", 32'(n < 40), 32'd1);
      in_valid1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
`ifdef SERIAL_RCA_OVF_EN
      q1o.push_back(ovf_model(1, {7'd0, a1}, {7'd0, b1}, cin1));
`endif
      @(negedge clk);
      in_valid1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
      n = 0;
      while (!out_valid1 && n < 40) begin @(negedge clk); n++; end
      chk("w1_latency", 32'(n), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("w1_result", 32'({cout1, sum1}), 32'(q1.pop_front()));
`ifdef SERIAL_RCA_OVF_EN
      chk("w1_ovf", 32'(ovf1), 32'(q1o.pop_front()));
`endif
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
    end

    // Random sweep, WIDTH=8
    for (int i = 0; i < 16; i++) begin
      int n;
      n = 0;
      while (!in_ready8 && n < 40) begin @(negedge clk); n++; end
      chk("w8_ready_wait", 32'(n < 40), 32'd1);
      in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
`ifdef SERIAL_RCA_OVF_EN
      q8o.push_back(ovf_model(8, a8, b8, cin8));
`endif
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      n = 0;
      while (!out_valid8 && n < 40) begin @(negedge clk); n++; end
      chk("w8_latency", 32'(n), 32'd8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("w8_result", 32'({cout8, sum8}), 32'(q8.pop_front()));
`ifdef SERIAL_RCA_OVF_EN
      chk("w8_ovf", 32'(ovf8), 32'(q8o.pop_front()));
`endif
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
